button_debouncer: RTL and testbench



---
 rtl/debounce_pkg.sv | 20 ++
 rtl/sync_chain.sv | 29 ++
 rtl/button_debouncer.sv | 120 ++++++++++++
 tb/tb_button_debouncer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : debounce_pkg
// Purpose  : Shared state encoding and default parameters for button_debouncer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sync_chain
// Purpose  : Multi-flop synchronizer for an asynchronous single-bit input.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : button_debouncer
// Purpose  : Synchronizes and debounces a raw button into a level plus edge
//            pulses. Optional toggle output enabled by DEBOUNCE_TOGGLE_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module button_debouncer
    import debounce_pkg::*;
#(
    parameter  int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic rise_pulse,
    output logic fall_pulse
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic toggle_q
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_btn_sync;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
`ifdef DEBOUNCE_TOGGLE_EN
    logic             r_toggle;
`endif

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (w_btn_sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_LOW;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
`ifdef DEBOUNCE_TOGGLE_EN
            r_toggle <= 1'b0;
`endif
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_btn_sync) begin
                        r_state <= S_WAIT_HIGH;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!w_btn_sync) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state  <= S_HIGH;
                        r_cnt    <= '0;
                        r_level  <= 1'b1;
                        r_rise   <= 1'b1;
`ifdef DEBOUNCE_TOGGLE_EN
                        r_toggle <= ~r_toggle;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!w_btn_sync) begin
                        r_state <= S_WAIT_LOW;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_LOW: begin
                    // db_level stays high here until the low level is accepted
                    if (w_btn_sync) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign db_level   = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
`ifdef DEBOUNCE_TOGGLE_EN
    assign toggle_q   = r_toggle;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_button_debouncer
// Purpose  : Directed and random checks of button_debouncer against a
//            run-length reference model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic clk;
    logic reset;
    logic btn_in;
    logic db_level;
    logic rise_pulse;
    logic fall_pulse;
`ifdef DEBOUNCE_TOGGLE_EN
    logic toggle_q;
`endif

    int vectors;
    int miscompares;

    button_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .db_level   (db_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .toggle_q   (toggle_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the FSM sees btn_in delayed by SYNC edges; a level is accepted
    // once DB+1 consecutive samples disagree with the current level.
    logic pipe[$];
    int   run;
    logic m_level, m_rise, m_fall, m_tog;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
            run     = 0;
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_tog   = 1'b0;
        end else begin
            logic s;
            s = pipe.pop_front();
            pipe.push_back(btn_in);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (s != m_level) begin
                run++;
                if (run == DB + 1) begin
                    m_level = s;
                    run     = 0;
                    if (s) begin
                        m_rise = 1'b1;
                        m_tog  = ~m_tog;
                    end else begin
                        m_fall = 1'b1;
                    end
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, got, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        chk("model_level", db_level, m_level);
        chk("model_rise", rise_pulse, m_rise);
        chk("model_fall", fall_pulse, m_fall);
`ifdef DEBOUNCE_TOGGLE_EN
        chk("model_toggle", toggle_q, m_tog);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pat [6];
        vectors     = 0;
        miscompares = 0;
        pat         = '{1, 0, 1, 1, 0, 1};
        btn_in      = 1'b1;
        reset       = 1'b1;
        #1 reset    = 1'b0;

        // Reset held with button pressed, then release and qualify
        repeat (3) tick();
        chk("rst_level", db_level, 1'b0);
        chk("rst_rise", rise_pulse, 1'b0);
        chk("rst_fall", fall_pulse, 1'b0);
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("press_rise", rise_pulse, e == 7);
            chk("press_level", db_level, e >= 7);
            chk("press_fall", fall_pulse, 1'b0);
`ifdef DEBOUNCE_TOGGLE_EN
            if (e == 7) chk("press_toggle", toggle_q, 1'b1);
`endif
        end
        repeat (10) tick();

        // Clean release
        btn_in = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("release_fall", fall_pulse, e == 7);
            chk("release_level", db_level, e < 7);
        end

        // Bounce then settle high
        for (int i = 0; i < 6; i++) begin
            btn_in = pat[i][0];
            tick();
            chk("bounce_rise", rise_pulse, 1'b0);
        end
        btn_in = 1'b1;
        for (int e = 7; e <= 16; e++) begin
            tick();
            chk("bounce_settle_rise", rise_pulse, e == 12);
`ifdef DEBOUNCE_TOGGLE_EN
            if (e == 12) chk("bounce_toggle", toggle_q, 1'b0);
`endif
        end

        // Short low glitch while high is ignored
        btn_in = 1'b0;
        tick();
        tick();
        btn_in = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            chk("glitch_level", db_level, 1'b1);
            chk("glitch_fall", fall_pulse, 1'b0);
        end

        // Return low, then reset in the middle of a press
        btn_in = 1'b0;
        repeat (14) tick();
        btn_in = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("midwait_level", db_level, 1'b0);
        chk("midwait_rise", rise_pulse, 1'b0);
        tick();
        tick();
        chk("midwait_held_rise", rise_pulse, 1'b0);
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("requal_rise", rise_pulse, e == 7);
`ifdef DEBOUNCE_TOGGLE_EN
            if (e == 7) chk("requal_toggle", toggle_q, 1'b1);
`endif
            if (e == 7) begin
                // Reset during the pulse cycle drops everything at once
                reset = 1'b0;
                #1;
                chk("midpulse_rise", rise_pulse, 1'b0);
                chk("midpulse_level", db_level, 1'b0);
                tick();
                reset = 1'b1;
                btn_in = 1'b0;
            end
        end
        repeat (10) tick();

        // Random bouncing with occasional resets
        for (int n = 0; n < 600; n++) begin
            btn_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            repeat ($urandom_range(1, 10)) tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
